// File: rtl/mux_n_ne1_reg.sv
// N-to-1 registered multiplexer with per-channel valid/accept handshake.
// Channels are chosen either directly by S or by a round-robin search after the last grant.
module mux_n_ne1_reg #(
  parameter int WIDTH = 24,
  parameter int N     = 4
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic [N*WIDTH-1:0]                   Hyrja,
  input  logic [N-1:0]                         Valid_in,
  input  logic [((N > 2) ? $clog2(N) : 1)-1:0] S,
  input  logic                                 Modi,
  input  logic                                 Gati,
  output logic [N-1:0]                         Pranuar,
  output logic [WIDTH-1:0]                     Dalja,
  output logic                                 Valid_out,
  output logic [((N > 2) ? $clog2(N) : 1)-1:0] Kanali
);

  localparam int SEL_W = (N > 2) ? $clog2(N) : 1;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  logic             cand_ok;
  logic             open;
  logic             capture;

  assign open    = !Valid_out || Gati;
  assign capture = open && cand_ok && !Reset;

  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (!Modi) begin
      if (32'(S) < N) begin
        cand    = S;
        cand_ok = Valid_in[S];
      end
    end else begin
      // Scan from the farthest offset inwards so the nearest valid channel after ptr wins.
      for (int unsigned d = N; d >= 1; d--) begin
        if (Valid_in[SEL_W'((32'(ptr) + d) % N)]) begin
          cand    = SEL_W'((32'(ptr) + d) % N);
          cand_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    Pranuar = '0;
    if (capture) Pranuar[cand] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Dalja     <= '0;
      Kanali    <= '0;
      Valid_out <= 1'b0;
      ptr       <= SEL_W'(N - 1);
    end else if (capture) begin
      Dalja     <= Hyrja[32'(cand)*WIDTH +: WIDTH];
      Kanali    <= cand;
      Valid_out <= 1'b1;
      if (Modi) ptr <= cand;
    end else if (open) begin
      Valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_ne1_reg.sv
// Directed bench for mux_n_ne1_reg: a 4-channel instance checked every cycle against a
// behavioural model plus literal expectations, and a 3-channel instance for out-of-range select.
module tb_mux_n_ne1_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel, 24-bit instance
  logic        rst = 1'b1;
  logic [95:0] hy = '0;
  logic [3:0]  vin = '0;
  logic [1:0]  s = '0;
  logic        modi = 1'b0;
  logic        gati = 1'b0;
  logic [3:0]  prn;
  logic [23:0] dalja;
  logic        vout;
  logic [1:0]  kanali;

  // 3-channel, 8-bit instance
  logic        rst3 = 1'b1;
  logic [23:0] hy3 = '0;
  logic [2:0]  vin3 = '0;
  logic [1:0]  s3 = '0;
  logic        modi3 = 1'b0;
  logic        gati3 = 1'b0;
  logic [2:0]  prn3;
  logic [7:0]  dal3;
  logic        vout3;
  logic [1:0]  kan3;

  mux_n_ne1_reg #(.WIDTH(24), .N(4)) u4 (
    .Clock(clk), .Reset(rst), .Hyrja(hy), .Valid_in(vin), .S(s), .Modi(modi), .Gati(gati),
    .Pranuar(prn), .Dalja(dalja), .Valid_out(vout), .Kanali(kanali)
  );

  mux_n_ne1_reg #(.WIDTH(8), .N(3)) u3 (
    .Clock(clk), .Reset(rst3), .Hyrja(hy3), .Valid_in(vin3), .S(s3), .Modi(modi3), .Gati(gati3),
    .Pranuar(prn3), .Dalja(dal3), .Valid_out(vout3), .Kanali(kan3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the 4-channel instance: a one-word buffer and a last-grant pointer.
  logic        m_ok = 1'b0;
  logic [23:0] m_dalja;
  logic [1:0]  m_kanali;
  logic        m_vout;
  int          m_ptr;

  always @(negedge clk) begin
    int  g;
    bit  gok;
    bit  cap;
    logic [3:0] exp_prn;
    if (m_ok) begin
      chk("model_dalja", 32'(dalja), 32'(m_dalja));
      chk("model_kanali", 32'(kanali), 32'(m_kanali));
      chk("model_valid_out", 32'(vout), 32'(m_vout));
    end
    g = 0;
    gok = 0;
    if (!modi) begin
      if (vin[s]) begin g = int'(s); gok = 1; end
    end else begin
      for (int d = 1; d <= 4 && !gok; d++) begin
        if (vin[(m_ptr + d) % 4]) begin g = (m_ptr + d) % 4; gok = 1; end
      end
    end
    cap = !rst && (!m_vout || gati) && gok;
    exp_prn = cap ? (4'b0001 << g) : 4'b0000;
    if (m_ok) chk("model_pranuar", 32'(prn), 32'(exp_prn));
    if (rst) begin
      m_dalja = '0; m_kanali = '0; m_vout = 1'b0; m_ptr = 3; m_ok = 1'b1;
    end else if (cap) begin
      m_dalja = hy[g*24 +: 24]; m_kanali = 2'(g); m_vout = 1'b1;
      if (modi) m_ptr = g;
    end else if (!m_vout || gati) begin
      m_vout = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) hy[k*24 +: 24] = 24'h100000 * (k + 1) + 24'(k);
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;
    settle();
    chk("reset_dalja", 32'(dalja), 32'h0);
    chk("reset_kanali", 32'(kanali), 32'h0);
    chk("reset_valid_out", 32'(vout), 32'h0);
    chk("reset_valid_out_n3", 32'(vout3), 32'h0);
    tick();

    // Direct select of channel 2
    hy[2*24 +: 24] = 24'hABCDEF;
    modi = 1'b0; s = 2'd2; vin = 4'b0100; gati = 1'b1;
    settle();
    chk("direct_pranuar", 32'(prn), 32'b0100);
    tick();
    chk("direct_dalja", 32'(dalja), 32'hABCDEF);
    chk("direct_kanali", 32'(kanali), 32'd2);
    chk("direct_valid_out", 32'(vout), 32'd1);

    // Stall for three cycles with a new word pending on channel 0
    gati = 1'b0; s = 2'd0; vin = 4'b0001; hy[0 +: 24] = 24'h111111;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_pranuar", 32'(prn), 32'h0);
      tick();
      chk("stall_dalja", 32'(dalja), 32'hABCDEF);
      chk("stall_kanali", 32'(kanali), 32'd2);
    end
    gati = 1'b1;
    settle();
    chk("unstall_pranuar", 32'(prn), 32'b0001);
    tick();
    chk("unstall_dalja", 32'(dalja), 32'h111111);
    chk("unstall_kanali", 32'(kanali), 32'd0);

    // Open stage with nothing valid drains the word, data held
    vin = 4'b0000;
    tick();
    chk("drain_valid_out", 32'(vout), 32'd0);
    chk("drain_dalja_hold", 32'(dalja), 32'h111111);

    // Round-robin straight after reset: 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) hy[k*24 +: 24] = 24'hC00000 + 24'(k);
    modi = 1'b1; vin = 4'b1111; gati = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] one;
      one = 4'b0001 << (i % 4);
      settle();
      chk("rr_pranuar", 32'(prn), 32'(one));
      tick();
      chk("rr_kanali", 32'(kanali), 32'(i % 4));
      chk("rr_dalja", 32'(dalja), 32'hC00000 + 32'(i % 4));
    end
    // One more grant (channel 1) leaves ptr at 1, then sparse 1001: 3, 0, 3
    settle();
    chk("rr_ptr1_pranuar", 32'(prn), 32'b0010);
    tick();
    vin = 4'b1001;
    settle(); chk("sparse_g3", 32'(prn), 32'b1000); tick();
    settle(); chk("sparse_g0", 32'(prn), 32'b0001); tick();
    settle(); chk("sparse_g3b", 32'(prn), 32'b1000); tick();
    chk("sparse_kanali", 32'(kanali), 32'd3);

    // ptr retained across a direct-mode grant: ptr=3, direct S=1, back to RR -> channel 0
    modi = 1'b0; s = 2'd1; vin = 4'b1111;
    settle(); chk("mode_direct_pranuar", 32'(prn), 32'b0010); tick();
    modi = 1'b1;
    settle(); chk("mode_rr_resume", 32'(prn), 32'b0001); tick();

    // Reset mid-stall discards the held word
    gati = 1'b0;
    tick();
    rst = 1'b1; vin = 4'b1111;
    settle();
    chk("rst_pranuar", 32'(prn), 32'h0);
    tick();
    rst = 1'b0; gati = 1'b1;
    settle();
    chk("rst_dalja", 32'(dalja), 32'h0);
    chk("rst_valid_out", 32'(vout), 32'h0);
    chk("rst_first_grant", 32'(prn), 32'b0001);
    tick();

    // 3-channel instance: out-of-range select
    hy3 = 24'hC3B2A1; modi3 = 1'b0; s3 = 2'd2; vin3 = 3'b111; gati3 = 1'b1;
    settle();
    chk("n3_direct_pranuar", 32'(prn3), 32'b100);
    tick();
    chk("n3_direct_dalja", 32'(dal3), 32'hC3);
    chk("n3_direct_valid_out", 32'(vout3), 32'd1);
    s3 = 2'd3;
    settle();
    chk("n3_oor_pranuar", 32'(prn3), 32'b000);
    tick();
    chk("n3_oor_valid_out", 32'(vout3), 32'd0);
    chk("n3_oor_dalja_hold", 32'(dal3), 32'hC3);
    chk("n3_oor_kanali_hold", 32'(kan3), 32'd2);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_ne1_reg.md
MUX_N_NE1_REG -- requirements
Module: mux_n_ne1_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the data width per channel.
REQ-002 The block SHALL have parameter N, default 4, legal 2..16, giving the channel count.
REQ-003 The block SHALL derive SEL_W = max(1, ceil(log2 N)) internally; it SHALL NOT be a user parameter.
REQ-004 The block SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1, with reset synchronous and active-high.
REQ-006 The block SHALL have port Hyrja, input, N*WIDTH, flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port Valid_in, input, N, per-channel data-valid.
REQ-008 The block SHALL have port S, input, SEL_W, the channel select used in direct mode.
REQ-009 The block SHALL have port Modi, input, 1, the mode: 0 = direct select by S, 1 = round-robin.
REQ-010 The block SHALL have port Gati, input, 1, the downstream ready.
REQ-011 The block SHALL have port Pranuar, output, N, a one-hot per-channel accept strobe (combinational).
REQ-012 The block SHALL have port Dalja, output, WIDTH, the registered selected data.
REQ-013 The block SHALL have port Valid_out, output, 1, asserted when Dalja holds an unconsumed word.
REQ-014 The block SHALL have port Kanali, output, SEL_W, the registered index of the channel that supplied Dalja.

Function
REQ-015 The output stage SHALL be open (load allowed) when Valid_out==0 or Gati==1.
REQ-016 In direct mode (Modi=0), the candidate SHALL be channel S; if S>=N, no channel is a candidate.
REQ-017 In round-robin mode (Modi=1), the candidate SHALL be the first k with Valid_in[k]=1, searching ptr+1, ptr+2, ... modulo N; if no channel is valid, there is no candidate.
REQ-018 A capture SHALL occur when the stage is open and the candidate exists with Valid_in[candidate]=1.
REQ-019 On a capture, Pranuar SHALL equal the one-hot of the candidate in the same cycle; otherwise Pranuar SHALL be all zeros.
REQ-020 On a capture, the next edge SHALL load Dalja with the candidate data, load Kanali with the candidate index, and set Valid_out=1; latency is one cycle from accept to Valid_out.
REQ-021 When the stage is open and no capture occurs, the next edge SHALL clear Valid_out; Dalja and Kanali SHALL hold their values.
REQ-022 When Valid_out==1 and Gati==0 (stall), Dalja, Kanali and Valid_out SHALL hold, and Pranuar SHALL be all zeros.
REQ-023 Simultaneous Gati=1 and a capture SHALL give back-to-back throughput of one word per cycle with no bubble.
REQ-024 Pointer ptr SHALL update to the granted index only on a capture in round-robin mode; it SHALL hold in direct mode and on stall.
REQ-025 A change of Modi SHALL take effect on the same cycle's candidate choice; ptr SHALL be retained across mode changes.
REQ-026 Wrap-around SHALL apply: with ptr=N-1, the search SHALL start at channel 0.

Reset
REQ-027 When Reset=1 at an edge, the block SHALL set Dalja=0, Kanali=0, Valid_out=0, and ptr=N-1, with Reset dominating any capture that cycle.
REQ-028 Pranuar SHALL be all zeros in any cycle where Reset=1.
REQ-029 A reset asserted mid-stall SHALL discard the held word; no Pranuar SHALL be issued for it.

Verification
REQ-030 Direct mode: N=4, Modi=0, S=2, Valid_in=0100, Hyrja ch2=24'hABCDEF, Gati=1 -> Pranuar=0100 that cycle; next cycle Dalja=ABCDEF, Kanali=2, Valid_out=1.
REQ-031 Stall: Valid_out=1, Gati=0 for 3 cycles, with new valid input -> Dalja/Kanali unchanged, Pranuar=0000; Gati=1 -> new word is accepted that cycle.
REQ-032 Round-robin: just after reset, Modi=1, Valid_in=1111, Gati=1 continuously -> grants 0,1,2,3,0 on consecutive cycles, with Kanali following one cycle later.
REQ-033 Sparse round-robin: ptr=1, Valid_in=1001 -> grant 3, then 0 (wrap), then 3.
REQ-034 Out-of-range select: N=3, Modi=0, S=3, Valid_in=111 -> Pranuar=000; Valid_out clears on the next open edge.
REQ-035 Reset mid-operation: Reset=1 while Valid_out=1 and Valid_in=1111 -> Pranuar=0000; next cycle Dalja=0, Valid_out=0; the first round-robin grant after reset is channel 0.
